arb_protocol_monitor: RTL and testbench
=======================================

// Module: arb_protocol_monitor
// PURPOSE
//  Parametrised passive monitor on the req/ack bus of an N-agent arbiter. Measures each
//  agent's wait latency, flags starvation and protocol errors, and exposes latency/fairness
//  coverage bits as registered, sticky outputs, so regressions and on-chip debug read the same
//  state. Sits beside the arbiter and drives nothing into it.
// PARAMETERS
//  NUM_AGENTS    2   number of requesting agents (>=2)
//  WAIT_W        8   width of each per-agent wait counter / max_wait field
//  STARVE_LIMIT  16  consecutive waiting cycles that mark an agent starved (1..2**WAIT_W-1)
//  ONEHOT_ACK    1   1: more than one ack bit set in a cycle is an error; 0: no check
// PORTS
//  clk             in   1              clock; all logic on posedge
//  rst             in   1              synchronous, active-high reset
//  req             in   NUM_AGENTS     request per agent
//  ack             in   NUM_AGENTS     grant/ack per agent, sampled in the same cycle as req
//  clr             in   1              synchronous clear of sticky flags and statistics
//  max_wait        out  NUM_AGENTS*WAIT_W  per-agent worst wait latency, agent i at [i*WAIT_W +: WAIT_W]
//  starve          out  NUM_AGENTS     sticky: agent waited STARVE_LIMIT consecutive cycles
//  err_ack_no_req  out  NUM_AGENTS     sticky: ack[i] while req[i]==0
//  err_drop_req    out  NUM_AGENTS     sticky: req[i] dropped while waiting, with no ack
//  err_multi_ack   out  1              sticky: $countones(ack)>1 (only when ONEHOT_ACK=1)
//  cov             out  NUM_AGENTS*4   sticky coverage, agent i at [i*4 +: 4] (bit map below)
// BEHAVIOUR
//  - Reset: all outputs and internal counters go to 0 on the posedge after rst is sampled high.
//    A wait in progress is discarded and counting restarts from 0.
//  - Per agent, wait_cnt (internal, WAIT_W bits):
//      req & !ack -> wait_cnt+1, saturating at 2**WAIT_W-1 (never wraps)
//      req &  ack -> grant. Latency L = current wait_cnt. wait_cnt <= 0
//      !req       -> wait_cnt <= 0
//  - Grant: if L > max_wait[i], max_wait[i] <= L.
//  - Coverage on grant: cov bit0 L==0, bit1 L==1, bit2 L>=2; bit3 grant while &req==1.
//  - Starvation: starve[i] set in the cycle after the waiting cycle in which wait_cnt
//    reaches STARVE_LIMIT-1 (i.e. STARVE_LIMIT consecutive req&!ack cycles).
//  - Error conditions:
//      err_ack_no_req[i]: ack[i] & !req[i]
//      err_drop_req[i]:   !req[i] & !ack[i] & wait_cnt!=0
//      err_multi_ack:     more than one ack bit set, only when ONEHOT_ACK=1; tied 0 when ONEHOT_ACK=0
//  - Latency: every output is registered and reflects the event one cycle after it is sampled.
//  - clr: sticky flags and cov <= 0; max_wait <= 0. wait_cnt is not affected.
//    If an event occurs in the same cycle as clr, the set wins: the flag is 1, or max_wait
//    loads L of the grant.
//  - Simultaneous errors on several agents are all recorded in the same cycle.
//  - rst has priority over clr and over all events.
// CONFIGURATION
//  - Macro ARB_MON_SVA_EN defined: a concurrent assertion is compiled for each error
//    condition and each starvation condition, disabled during rst, and reports agent index.
//  - Macro absent: no assertions; sticky output flags only. Port list is identical either way.
// STRUCTURE
//  - Package arb_mon_pkg holds the cov bit-index constants (COV_LAT0=0, COV_LAT1=1,
//    COV_LAT2P=2, COV_ALL_REQ=3) and COV_W=4.
//  - Sub-module arb_mon_agent holds wait_cnt, max_wait, starve, the per-agent error flags and
//    the cov nibble for one agent. The top instantiates NUM_AGENTS copies in a generate loop.
//    The top also computes &req, the multi-ack check, and the optional SVA.
// TESTING (NUM_AGENTS=2, WAIT_W=4, STARVE_LIMIT=4, ONEHOT_ACK=1 unless stated)
//  1. req[0]=1 cycles 0..2, ack[0]=1 cycle 2 -> cycle 3: max_wait[0]=2, cov[2]=1, no errors
//  2. req=2'b11 both waiting, ack=2'b01 at cycle 0 -> cov[3]=1 (L=0 and all-req), cov[0]=1.
//     Then ack=2'b10 next cycle -> cov[5]=1 (agent1 L=1), cov[7]=0 (req no longer all-high)
//  3. req[1]=1, ack[1]=0 for 4 cycles -> starve[1]=1 on cycle 4. It stays 1 and clears only on
//     the cycle after clr=1.
//  4. ack=2'b01, req=2'b00 -> err_ack_no_req=2'b01. ack=2'b11 with req=2'b11 -> err_multi_ack=1.
//     Rerun with ONEHOT_ACK=0 -> err_multi_ack stays 0.
//  5. req[0]=1 for 3 cycles with no ack, then req[0]=0 -> err_drop_req[0]=1. Then wait 20 cycles
//     and grant -> max_wait[0]=15 (saturated, no wrap).
//  6. rst=1 while agent0 has wait_cnt=3 -> all outputs 0 next cycle. A grant 1 cycle after
//     rst drops gives max_wait[0]=1.

Source files
------------

// File: rtl/arb_mon_pkg.sv
// Shared constants for the arbiter protocol monitor: coverage nibble layout per agent.
package arb_mon_pkg;

  localparam int COV_W       = 4;
  localparam int COV_LAT0    = 0;
  localparam int COV_LAT1    = 1;
  localparam int COV_LAT2P   = 2;
  localparam int COV_ALL_REQ = 3;

endpackage : arb_mon_pkg

// File: rtl/arb_mon_agent.sv
// One agent's slice of the arbiter monitor: wait counter, worst latency, sticky flags, coverage.
// With ARB_MON_SVA_EN defined the live wait counter is exported for the top-level assertions.
module arb_mon_agent
  import arb_mon_pkg::*;
#(
  parameter int WAIT_W       = 8,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req,
  input  logic              ack,
  input  logic              all_req,
  output logic [WAIT_W-1:0] max_wait,
  output logic              starve,
  output logic              err_ack_no_req,
  output logic              err_drop_req,
  output logic [COV_W-1:0]  cov
`ifdef ARB_MON_SVA_EN
  ,
  output logic [WAIT_W-1:0] wait_cnt
`endif
);

  localparam logic [WAIT_W-1:0] CNT_MAX   = '1;
  localparam logic [WAIT_W-1:0] STARVE_TH = WAIT_W'(STARVE_LIMIT - 1);

  logic [WAIT_W-1:0] cnt;
  logic              waiting;
  logic              grant;
  logic              ack_no_req_ev;
  logic              drop_ev;
  logic              starve_ev;
  logic [COV_W-1:0]  cov_ev;

`ifdef ARB_MON_SVA_EN
  assign wait_cnt = cnt;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    cov_ev        = '0;
    waiting       = req & ~ack;
    grant         = req & ack;
    ack_no_req_ev = ack & ~req;
    drop_ev       = ~req & ~ack & (cnt != '0);
    // cnt already holds STARVE_LIMIT-1 on the STARVE_LIMIT-th consecutive waiting cycle
    starve_ev     = waiting & (cnt >= STARVE_TH);
    if (grant) begin
      cov_ev[COV_LAT0]    = (cnt == '0);
      cov_ev[COV_LAT1]    = (cnt == WAIT_W'(1));
      cov_ev[COV_LAT2P]   = (cnt >= WAIT_W'(2));
      cov_ev[COV_ALL_REQ] = all_req;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= '0;
      max_wait       <= '0;
      starve         <= 1'b0;
      err_ack_no_req <= 1'b0;
      err_drop_req   <= 1'b0;
      cov            <= '0;
    end else begin
      if (waiting) begin
        if (cnt != CNT_MAX) cnt <= cnt + WAIT_W'(1);
      end else begin
        cnt <= '0;
      end

      // An event seen in the clr cycle survives the clear
      starve         <= starve_ev     | (starve & ~clr);
      err_ack_no_req <= ack_no_req_ev | (err_ack_no_req & ~clr);
      err_drop_req   <= drop_ev       | (err_drop_req & ~clr);
      cov            <= cov_ev        | (cov & {COV_W{~clr}});

      if (grant && (clr || (cnt > max_wait))) max_wait <= cnt;
      else if (clr)                           max_wait <= '0;
    end
  end

endmodule : arb_mon_agent

// File: rtl/arb_protocol_monitor.sv
// Passive req/ack monitor for an N-agent arbiter: latency, starvation, protocol errors, coverage.
// Optional macro ARB_MON_SVA_EN adds concurrent assertions for every error and starvation case.
module arb_protocol_monitor
  import arb_mon_pkg::*;
#(
  parameter int NUM_AGENTS   = 2,
  parameter int WAIT_W       = 8,
  parameter int STARVE_LIMIT = 16,
  parameter bit ONEHOT_ACK   = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_AGENTS-1:0]        req,
  input  logic [NUM_AGENTS-1:0]        ack,
  input  logic                         clr,
  output logic [NUM_AGENTS*WAIT_W-1:0] max_wait,
  output logic [NUM_AGENTS-1:0]        starve,
  output logic [NUM_AGENTS-1:0]        err_ack_no_req,
  output logic [NUM_AGENTS-1:0]        err_drop_req,
  output logic                         err_multi_ack,
  output logic [NUM_AGENTS*COV_W-1:0]  cov
);

  logic all_req;

  assign all_req = &req;

`ifdef ARB_MON_SVA_EN
  logic [WAIT_W-1:0] wait_cnt [NUM_AGENTS];
`endif

  for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_agent
    arb_mon_agent #(
      .WAIT_W       (WAIT_W),
      .STARVE_LIMIT (STARVE_LIMIT)
    ) u_agent (
      .clk            (clk),
      .rst            (rst),
      .clr            (clr),
      .req            (req[i]),
      .ack            (ack[i]),
      .all_req        (all_req),
      .max_wait       (max_wait[i*WAIT_W +: WAIT_W]),
      .starve         (starve[i]),
      .err_ack_no_req (err_ack_no_req[i]),
      .err_drop_req   (err_drop_req[i]),
      .cov            (cov[i*COV_W +: COV_W])
`ifdef ARB_MON_SVA_EN
      ,
      .wait_cnt       (wait_cnt[i])
`endif
    );
  end

  if (ONEHOT_ACK) begin : g_onehot
    logic multi_ev;

    // Clearing the lowest set bit leaves something only when two or more bits are set
    assign multi_ev = |(ack & (ack - NUM_AGENTS'(1)));

    always_ff @(posedge clk) begin
      if (rst) err_multi_ack <= 1'b0;
      else     err_multi_ack <= multi_ev | (err_multi_ack & ~clr);
    end
  end else begin : g_no_onehot
    assign err_multi_ack = 1'b0;
  end

`ifdef ARB_MON_SVA_EN
  for (genvar i = 0; i < NUM_AGENTS; i++) begin : g_sva
    a_ack_no_req : assert property (@(posedge clk) disable iff (rst)
      !(ack[i] && !req[i]))
      else $error("arb_mon: ack without req on agent %0d", i);

    a_drop_req : assert property (@(posedge clk) disable iff (rst)
      !(!req[i] && !ack[i] && (wait_cnt[i] != '0)))
      else $error("arb_mon: req dropped while waiting on agent %0d", i);

    a_starve : assert property (@(posedge clk) disable iff (rst)
      !(req[i] && !ack[i] && (wait_cnt[i] >= WAIT_W'(STARVE_LIMIT - 1))))
      else $error("arb_mon: agent %0d starved", i);
  end

  if (ONEHOT_ACK) begin : g_sva_onehot
    a_multi_ack : assert property (@(posedge clk) disable iff (rst) $onehot0(ack))
      else $error("arb_mon: multiple acks 0x%0h", ack);
  end
`endif

endmodule : arb_protocol_monitor

// File: tb/tb_arb_protocol_monitor.sv
// Directed scoreboard bench for arb_protocol_monitor (2 agents, 4-bit counters, limit 4).
module tb_arb_protocol_monitor;

  localparam int NA = 2;
  localparam int WW = 4;

  typedef enum int { S_MAXW, S_STARVE, S_ANR, S_DROP, S_MULTI, S_COV, S_MULTI_B } sel_e;

  typedef struct {
    string       tag;
    sel_e        sel;
    logic [31:0] exp;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NA-1:0]    req = '0;
  logic [NA-1:0]    ack = '0;
  logic             clr = 1'b0;
  logic [NA*WW-1:0] max_wait, b_max_wait;
  logic [NA-1:0]    starve, err_ack_no_req, err_drop_req;
  logic [NA-1:0]    b_starve, b_err_ack_no_req, b_err_drop_req;
  logic             err_multi_ack, b_err_multi_ack;
  logic [NA*4-1:0]  cov, b_cov;

  exp_t q[$];
  int   n_vec = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  arb_protocol_monitor #(
    .NUM_AGENTS(NA), .WAIT_W(WW), .STARVE_LIMIT(4), .ONEHOT_ACK(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .clr(clr),
    .max_wait(max_wait), .starve(starve), .err_ack_no_req(err_ack_no_req),
    .err_drop_req(err_drop_req), .err_multi_ack(err_multi_ack), .cov(cov)
  );

  arb_protocol_monitor #(
    .NUM_AGENTS(NA), .WAIT_W(WW), .STARVE_LIMIT(4), .ONEHOT_ACK(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .clr(clr),
    .max_wait(b_max_wait), .starve(b_starve), .err_ack_no_req(b_err_ack_no_req),
    .err_drop_req(b_err_drop_req), .err_multi_ack(b_err_multi_ack), .cov(b_cov)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_obs(input sel_e s);
    case (s)
      S_MAXW:    return 32'(max_wait);
      S_STARVE:  return 32'(starve);
      S_ANR:     return 32'(err_ack_no_req);
      S_DROP:    return 32'(err_drop_req);
      S_MULTI:   return 32'(err_multi_ack);
      S_COV:     return 32'(cov);
      S_MULTI_B: return 32'(b_err_multi_ack);
      default:   return 32'hdead_beef;
    endcase
  endfunction

  task automatic expect_out(input string tag, input sel_e s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic expect_zero(input string tag);
    expect_out({tag, ".max_wait"}, S_MAXW, 0);
    expect_out({tag, ".starve"}, S_STARVE, 0);
    expect_out({tag, ".ack_no_req"}, S_ANR, 0);
    expect_out({tag, ".drop_req"}, S_DROP, 0);
    expect_out({tag, ".multi_ack"}, S_MULTI, 0);
    expect_out({tag, ".cov"}, S_COV, 0);
  endtask

  // Apply one cycle of stimulus, then score every expectation queued for this edge
  task automatic cycle(input logic [NA-1:0] r, input logic [NA-1:0] a,
                       input logic c = 1'b0, input logic rs = 1'b0);
    exp_t e;
    @(negedge clk);
    req = r;
    ack = a;
    clr = c;
    rst = rs;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, get_obs(e.sel), e.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    cycle(2'b00, 2'b00, 1'b0, 1'b1);
    expect_zero("reset");
    cycle(2'b00, 2'b00, 1'b0, 1'b1);

    // 1: agent0 granted after two waiting cycles
    cycle(2'b01, 2'b00);
    cycle(2'b01, 2'b00);
    expect_out("t1.max_wait", S_MAXW, 32'h02);
    expect_out("t1.cov", S_COV, 32'h04);
    expect_out("t1.ack_no_req", S_ANR, 0);
    expect_out("t1.drop_req", S_DROP, 0);
    cycle(2'b01, 2'b01);
    cycle(2'b00, 2'b00);
    expect_out("t1.clr.max_wait", S_MAXW, 0);
    expect_out("t1.clr.cov", S_COV, 0);
    cycle(2'b00, 2'b00, 1'b1);

    // 2: all-request coverage, then agent1 L=1 without all-req
    expect_out("t2a.cov", S_COV, 32'h09);
    expect_out("t2a.max_wait", S_MAXW, 0);
    cycle(2'b11, 2'b01);
    expect_out("t2b.cov", S_COV, 32'h29);
    expect_out("t2b.max_wait", S_MAXW, 32'h10);
    expect_out("t2b.drop_req", S_DROP, 0);
    cycle(2'b10, 2'b10);
    cycle(2'b00, 2'b00, 1'b1);

    // 3: agent1 starves on the fourth waiting cycle, sticky until clr
    cycle(2'b10, 2'b00);
    cycle(2'b10, 2'b00);
    expect_out("t3.starve_early", S_STARVE, 0);
    cycle(2'b10, 2'b00);
    expect_out("t3.starve", S_STARVE, 32'h2);
    cycle(2'b10, 2'b00);
    expect_out("t3.grant.max_wait", S_MAXW, 32'h40);
    expect_out("t3.grant.cov", S_COV, 32'h40);
    expect_out("t3.grant.starve", S_STARVE, 32'h2);
    cycle(2'b10, 2'b10);
    expect_out("t3.sticky", S_STARVE, 32'h2);
    cycle(2'b00, 2'b00);
    expect_out("t3.clr.starve", S_STARVE, 0);
    expect_out("t3.clr.max_wait", S_MAXW, 0);
    cycle(2'b00, 2'b00, 1'b1);

    // 4: ack without req, multi-ack in both configurations, set wins over clr
    expect_out("t4.ack_no_req", S_ANR, 32'h1);
    cycle(2'b00, 2'b01);
    expect_out("t4.multi", S_MULTI, 32'h1);
    expect_out("t4.multi_off", S_MULTI_B, 0);
    expect_out("t4.multi.cov", S_COV, 32'h99);
    expect_out("t4.multi.ack_no_req", S_ANR, 32'h1);
    cycle(2'b11, 2'b11);
    expect_out("t4.clrset.ack_no_req", S_ANR, 32'h2);
    expect_out("t4.clrset.multi", S_MULTI, 0);
    expect_out("t4.clrset.cov", S_COV, 0);
    cycle(2'b00, 2'b10, 1'b1);
    cycle(2'b00, 2'b00, 1'b1);

    // 5: dropped request, then saturating wait
    for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00);
    expect_out("t5.drop_req", S_DROP, 32'h1);
    cycle(2'b00, 2'b00);
    for (int i = 0; i < 20; i++) cycle(2'b01, 2'b00);
    expect_out("t5.sat.max_wait", S_MAXW, 32'h0F);
    expect_out("t5.sat.cov", S_COV, 32'h04);
    expect_out("t5.sat.starve", S_STARVE, 32'h1);
    expect_out("t5.sat.drop_req", S_DROP, 32'h1);
    cycle(2'b01, 2'b01);
    cycle(2'b01, 2'b00);
    expect_out("t5.keep.max_wait", S_MAXW, 32'h0F);
    expect_out("t5.keep.cov", S_COV, 32'h06);
    cycle(2'b01, 2'b01);

    // 6: reset mid-wait, with clr and an error also present, then a fresh grant
    for (int i = 0; i < 3; i++) cycle(2'b01, 2'b00);
    expect_zero("t6.rst");
    expect_out("t6.rst.multi_off", S_MULTI_B, 0);
    cycle(2'b00, 2'b01, 1'b1, 1'b1);
    cycle(2'b01, 2'b00);
    expect_out("t6.max_wait", S_MAXW, 32'h01);
    expect_out("t6.cov", S_COV, 32'h02);
    expect_out("t6.ack_no_req", S_ANR, 0);
    cycle(2'b01, 2'b01);
    cycle(2'b00, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_arb_protocol_monitor
